winlose_scene_ctrl: RTL and testbench
=====================================

Name: winlose_scene_ctrl

Overview:
- Scene sequencer for the game's top-level flow: START -> MENU -> PLAY1/2/3 -> WIN/LOSE -> MENU.
- Drives the `scene` code and the `winLose_cnt` blink counter that the win/lose renderer consumes.
- Accepts "tap to continue" only after a minimum display time, and signals every scene entry to downstream logic.

Parameters:
- TICK_DIV, 6, number of frame_tick pulses per winLose_cnt increment (legal range 1..255).
- LOCKOUT, 8, number of winLose_cnt increments after entering WIN/LOSE before a tap is accepted (legal range 0..15).

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- tap  in  1  raw tap/click level; edge-detected internally.
- level_valid  in  1  level-select strobe, qualified in MENU only.
- level_sel  in  2  requested level: 1..3 select PLAY1..PLAY3; 0 is ignored.
- win  in  1  game-won pulse from play logic.
- lose  in  1  game-lost pulse from play logic.
- scene  out  3  current scene: 0 START, 1 MENU, 2 PLAY1, 3 PLAY2, 4 PLAY3, 5 WIN, 6 LOSE.
- winLose_cnt  out  4  blink counter; bit 3 gates the "Tap To Continue" text.
- scene_enter  out  1  one-cycle pulse in the first cycle a new scene value is visible.
- tap_accept  out  1  one-cycle pulse when a tap causes a scene transition.

Behaviour:
- Clock and reset:
  - Single clock domain. All state is registered on posedge clk.
  - rst is synchronous and active-high, and overrides all other inputs.
- Reset values:
  - scene=0 (START), winLose_cnt=0, scene_enter=0, tap_accept=0.
  - Internal div_cnt=0, lock_cnt=0.
  - Tap history register tap_q=1, so a tap held through reset is not treated as an edge.
- Tap edge detect:
  - tap_rise = tap & ~tap_q, with tap_q <= tap every cycle.
  - A held tap yields exactly one tap_rise.
- Transitions are evaluated every cycle and the new scene is visible on the next edge (1-cycle latency):
  - START: tap_rise -> MENU, with tap_accept=1.
  - MENU: level_valid with level_sel=1/2/3 -> PLAY1/PLAY2/PLAY3. level_sel=0 is ignored, and tap is ignored.
  - PLAYn, lose=1 -> LOSE. This holds even if win=1 in the same cycle (lose has priority).
  - PLAYn, win=1 with lose=0 -> WIN.
  - PLAYn: level_valid and tap are ignored.
  - WIN/LOSE: tap_rise with armed=1 -> MENU, with tap_accept=1.
  - WIN/LOSE: tap_rise with armed=0 is discarded and never queued.
  - WIN/LOSE: win, lose and level_valid are ignored.
  - Encodings 7 (or any illegal value): next cycle -> START, without scene_enter.
- scene_enter:
  - Registered; equals 1 in exactly the cycle where scene first shows a new legal value reached by a transition.
  - Not asserted out of reset.
- Blink counter (WIN/LOSE only):
  - On frame_tick: if div_cnt==TICK_DIV-1, then div_cnt<=0 and winLose_cnt<=winLose_cnt+1; otherwise div_cnt<=div_cnt+1.
  - winLose_cnt wraps 15->0. It holds when frame_tick=0.
  - Each winLose_cnt increment also increments lock_cnt, which saturates at LOCKOUT.
  - armed = (lock_cnt==LOCKOUT). LOCKOUT=0 means armed immediately on entry.
- On any scene transition: winLose_cnt, div_cnt and lock_cnt clear to 0 in the same edge that updates scene.
- Outside WIN/LOSE: winLose_cnt, div_cnt and lock_cnt are held at 0.
- Simultaneous events:
  - frame_tick in the same cycle as a transition: the clear wins and the tick is dropped.
  - tap_rise and arming in the same cycle: the tap is rejected, because armed is sampled from the registered lock_cnt.
- Blink timing with defaults at 60 frames/s:
  - 0.1 s per winLose_cnt count.
  - Text on/off period is 0.8 s each.
  - Tap is accepted from 0.8 s after entry.

Test Plan:
- Reset and START exit:
  - Hold tap=1 through rst, then release rst -> scene stays 0.
  - Drop tap, then raise it -> scene=1 one cycle later, with scene_enter=1 and tap_accept=1 for 1 cycle.
- Level select:
  - In MENU, level_valid=1 with level_sel=0 -> scene stays 1.
  - Then level_sel=3 -> scene=4 next cycle, with scene_enter pulse.
- Win/lose priority:
  - In PLAY2, win=1 and lose=1 in the same cycle -> scene=6.
  - Separate run: win=1 only -> scene=5, winLose_cnt=0.
- Blink timing:
  - In WIN with TICK_DIV=6, apply 48 frame_tick pulses -> winLose_cnt=8 after tick 48, and bit 3 rises exactly then.
  - Apply 96 ticks -> winLose_cnt wraps to 0.
- Lockout:
  - In LOSE, tap_rise after 47 ticks -> ignored, no tap_accept.
  - tap_rise after 48 ticks -> scene=1 and tap_accept=1.
  - A held tap from before arming does not transition.
- Mid-operation reset:
  - rst asserted in WIN with winLose_cnt=5 -> next cycle scene=0, winLose_cnt=0, all pulses 0.

Source files
------------

// File: rtl/winlose_scene_if.sv
// Scene controller bus: frame/tap/level/game-result inputs and scene status outputs.
interface winlose_scene_if;
  logic       frame_tick;
  logic       tap;
  logic       level_valid;
  logic [1:0] level_sel;
  logic       win;
  logic       lose;
  logic [2:0] scene;
  logic [3:0] winLose_cnt;
  logic       scene_enter;
  logic       tap_accept;

  modport master (
    output frame_tick, tap, level_valid, level_sel, win, lose,
    input  scene, winLose_cnt, scene_enter, tap_accept
  );

  modport slave (
    input  frame_tick, tap, level_valid, level_sel, win, lose,
    output scene, winLose_cnt, scene_enter, tap_accept
  );
endinterface

// File: rtl/winlose_scene_ctrl.sv
// Top-level game scene sequencer: START -> MENU -> PLAYn -> WIN/LOSE -> MENU.
// Runs the win/lose blink counter and gates "tap to continue" behind a lockout.
module winlose_scene_ctrl #(
  parameter int unsigned TICK_DIV = 6,
  parameter int unsigned LOCKOUT  = 8
) (
  input  logic            clk,
  input  logic            rst,
  winlose_scene_if.slave  bus
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_MENU  = 3'd1,
    S_PLAY1 = 3'd2,
    S_PLAY2 = 3'd3,
    S_PLAY3 = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } scene_t;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] LOCK_MAX = 4'(LOCKOUT);

  scene_t     scene_q;
  logic [3:0] wl_cnt;
  logic [7:0] div_cnt;
  logic [3:0] lock_cnt;
  logic       tap_q;
  logic       enter_q;
  logic       accept_q;

  logic       tap_rise;
  logic       armed;

  // Rising edge of tap and lockout status, both derived from registered history.
  always_comb begin
    tap_rise = bus.tap & ~tap_q;
    armed    = (lock_cnt == LOCK_MAX);
  end

  // Scene FSM with blink/lockout counters; counters clear on every scene change.
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q  <= S_START;
      wl_cnt   <= '0;
      div_cnt  <= '0;
      lock_cnt <= '0;
      tap_q    <= 1'b1;
      enter_q  <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      tap_q    <= bus.tap;
      enter_q  <= 1'b0;
      accept_q <= 1'b0;
      case (scene_q)
        S_START: begin
          wl_cnt   <= '0;
          div_cnt  <= '0;
          lock_cnt <= '0;
          if (tap_rise) begin
            scene_q  <= S_MENU;
            enter_q  <= 1'b1;
            accept_q <= 1'b1;
          end
        end
        S_MENU: begin
          wl_cnt   <= '0;
          div_cnt  <= '0;
          lock_cnt <= '0;
          if (bus.level_valid && (bus.level_sel != 2'd0)) begin
            scene_q <= scene_t'(3'd1 + {1'b0, bus.level_sel});
            enter_q <= 1'b1;
          end
        end
        S_PLAY1, S_PLAY2, S_PLAY3: begin
          wl_cnt   <= '0;
          div_cnt  <= '0;
          lock_cnt <= '0;
          if (bus.lose) begin
            scene_q <= S_LOSE;
            enter_q <= 1'b1;
          end else if (bus.win) begin
            scene_q <= S_WIN;
            enter_q <= 1'b1;
          end
        end
        S_WIN, S_LOSE: begin
          if (tap_rise && armed) begin
            scene_q  <= S_MENU;
            enter_q  <= 1'b1;
            accept_q <= 1'b1;
            wl_cnt   <= '0;
            div_cnt  <= '0;
            lock_cnt <= '0;
          end else if (bus.frame_tick) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              wl_cnt  <= wl_cnt + 4'd1;
              if (!armed) lock_cnt <= lock_cnt + 4'd1;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        default: begin
          scene_q  <= S_START;
          wl_cnt   <= '0;
          div_cnt  <= '0;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.scene       = scene_q;
  assign bus.winLose_cnt = wl_cnt;
  assign bus.scene_enter = enter_q;
  assign bus.tap_accept  = accept_q;

endmodule

// File: tb/tb_winlose_scene_ctrl.sv
// Directed bench for winlose_scene_ctrl with default TICK_DIV=6, LOCKOUT=8.
module tb_winlose_scene_ctrl;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  winlose_scene_if bus ();

  winlose_scene_ctrl #(.TICK_DIV(6), .LOCKOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic check_state(input string tag, input int sc, input int cnt,
                             input int en, input int acc);
    check({tag, ".scene"},  int'(bus.scene),       sc);
    check({tag, ".cnt"},    int'(bus.winLose_cnt), cnt);
    check({tag, ".enter"},  int'(bus.scene_enter), en);
    check({tag, ".accept"}, int'(bus.tap_accept),  acc);
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.tap         = 1'b1;
    bus.level_valid = 1'b0;
    bus.level_sel   = 2'd0;
    bus.win         = 1'b0;
    bus.lose        = 1'b0;
    #1;
    repeat (3) step();
    check_state("reset", 0, 0, 0, 0);

    // Tap held through reset is not an edge
    rst = 1'b0;
    step(); step();
    check_state("held_tap", 0, 0, 0, 0);

    // START -> MENU on a fresh tap edge
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; step();
    check_state("to_menu", 1, 0, 1, 1);
    step();
    check_state("menu_hold", 1, 0, 0, 0);

    // MENU ignores level_sel=0 and taps
    bus.tap = 1'b0; bus.level_valid = 1'b1; bus.level_sel = 2'd0; step();
    bus.tap = 1'b1; step();
    check_state("sel0", 1, 0, 0, 0);
    bus.level_sel = 2'd3; step();
    check_state("to_play3", 4, 0, 1, 0);
    bus.level_valid = 1'b0; step();
    check_state("play3_hold", 4, 0, 0, 0);

    // PLAY ignores level_valid and taps
    bus.tap = 1'b0; bus.level_valid = 1'b1; bus.level_sel = 2'd1; step();
    bus.tap = 1'b1; step();
    bus.level_valid = 1'b0;
    check_state("play_ign", 4, 0, 0, 0);

    // Win only -> WIN
    bus.win = 1'b1; step();
    bus.win = 1'b0;
    check_state("to_win", 5, 0, 1, 0);

    // Blink: bit 3 rises exactly on tick 48, wraps at 96
    ticks(47);
    check("cnt47", int'(bus.winLose_cnt), 7);
    check("bit3_47", int'(bus.winLose_cnt[3]), 0);
    ticks(1);
    check("cnt48", int'(bus.winLose_cnt), 8);
    check("bit3_48", int'(bus.winLose_cnt[3]), 1);
    ticks(47);
    check("cnt95", int'(bus.winLose_cnt), 15);
    ticks(1);
    check("cnt96", int'(bus.winLose_cnt), 0);
    check("win_stays", int'(bus.scene), 5);

    // Armed tap in WIN returns to MENU
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; step();
    check_state("win_exit", 1, 0, 1, 1);

    // MENU -> PLAY2, then win+lose together -> LOSE
    bus.level_valid = 1'b1; bus.level_sel = 2'd2; step();
    bus.level_valid = 1'b0;
    check_state("to_play2", 3, 0, 1, 0);
    bus.win = 1'b1; bus.lose = 1'b1; step();
    bus.win = 1'b0; bus.lose = 1'b0;
    check_state("to_lose", 6, 0, 1, 0);

    // Lockout: tap after 47 ticks ignored
    ticks(47);
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; step();
    check_state("tap47", 6, 7, 0, 0);
    // Tap edge in the same cycle as the arming tick is rejected, then held
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; bus.frame_tick = 1'b1; step();
    bus.frame_tick = 1'b0;
    check_state("tap_arm_same", 6, 8, 0, 0);
    step(); step(); step();
    check_state("held_armed", 6, 8, 0, 0);
    // Fresh tap once armed is accepted
    bus.tap = 1'b0; step();
    bus.tap = 1'b1; step();
    check_state("lose_exit", 1, 0, 1, 1);

    // Mid-operation reset in WIN with count 5
    bus.level_valid = 1'b1; bus.level_sel = 2'd1; step();
    bus.level_valid = 1'b0;
    check_state("to_play1", 2, 0, 1, 0);
    bus.win = 1'b1; step();
    bus.win = 1'b0;
    check("to_win2", int'(bus.scene), 5);
    ticks(30);
    check("cnt30", int'(bus.winLose_cnt), 5);
    rst = 1'b1; bus.frame_tick = 1'b1; step();
    bus.frame_tick = 1'b0;
    check_state("mid_rst", 0, 0, 0, 0);
    rst = 1'b0; step();
    check_state("post_rst", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
